// File: rtl/coms_pkg.sv
// Shared definitions for the motor-board frame protocol: magics, lengths,
// receiver states and the byte-wise CRC-16 (poly 0x8005, MSB first).
package coms_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        RECEIVE = 2'd1,
        CHECK   = 2'd2
    } state_t;

    localparam logic [31:0] MAGIC_STATUS     = 32'h1CEB00DA;
    localparam logic [31:0] MAGIC_CONTROL    = 32'hBAADA555;
    localparam logic [31:0] MAGIC_SETPOINT   = 32'hD0D0D0D0;
    localparam logic [31:0] MAGIC_STATUS_REQ = 32'h1CE1CEBB;

    // Post-magic lengths, CRC bytes included
    localparam logic [7:0] LEN_STATUS  = 8'd26;
    localparam logic [7:0] LEN_CONTROL = 8'd30;

    function automatic logic [15:0] nextCRC16_D8(input logic [7:0] data,
                                                 input logic [15:0] crc);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h8005;
        end
        return c;
    endfunction

endpackage

// File: rtl/coms_frame_rx.sv
// Multi-type UART frame receiver: hunts for a magic, collects the payload,
// verifies the trailing CRC and delivers the whole frame in one pulse.
module coms_frame_rx
    import coms_pkg::*;
#(
    parameter int                      NUM_TYPES      = 2,
    parameter int                      MAX_LEN        = 32,
    parameter logic [NUM_TYPES*32-1:0] MAGICS         = {MAGIC_CONTROL, MAGIC_STATUS},
    parameter logic [NUM_TYPES*8-1:0]  LENGTHS        = {LEN_CONTROL, LEN_STATUS},
    parameter int                      TIMEOUT_CYCLES = 48000,
    localparam int                     TW             = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1
) (
    input  logic                 clock48MHz,
    input  logic                 reset,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_byte,
    output logic                 frame_valid,
    output logic [TW-1:0]        frame_type,
    output logic [MAX_LEN*8-1:0] payload,
    output logic [7:0]           payload_len,
    output logic                 crc_error,
    output logic                 timeout_error,
    output logic [15:0]          frames_ok,
    output logic [15:0]          crc_err_count,
    output logic                 busy
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t              state_reg, state_next;
    logic [31:0]         window_reg, window_shift;
    logic [15:0]         crc_reg, rx_crc_reg;
    logic [7:0]          count_reg;
    logic [CW-1:0]       idle_reg;
    logic [TW-1:0]       type_reg, match_type;
    logic [7:0]          buffer_reg [MAX_LEN];
    logic [MAX_LEN*8-1:0] payload_next;
    logic [7:0]          len_cur;
    logic                match, last_byte, idle_done, crc_ok;
    logic                hunt_shift, sync, accept, crc_update, crc_capture;
    logic                timeout_hit, good_frame, bad_frame;

    // A byte seen during CHECK starts a fresh window
    assign window_shift = {(state_reg == CHECK) ? 24'h0 : window_reg[23:0], rx_byte};

    always_comb begin
        match      = 1'b0;
        match_type = '0;
        for (int t = NUM_TYPES - 1; t >= 0; t--) begin
            if (window_shift == MAGICS[32*t +: 32]) begin
                match      = 1'b1;
                match_type = TW'(t);
            end
        end
    end

    always_comb begin
        len_cur = LENGTHS[7:0];
        for (int t = 0; t < NUM_TYPES; t++) begin
            if (type_reg == TW'(t)) len_cur = LENGTHS[8*t +: 8];
        end
    end

    assign last_byte = (count_reg == len_cur - 8'd1);
    assign idle_done = (idle_reg == CW'(TIMEOUT_CYCLES - 1));
    assign crc_ok    = (crc_reg == rx_crc_reg);

    always_ff @(posedge clock48MHz or posedge reset) begin
        if (reset) state_reg <= HUNT;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            HUNT:    if (rx_valid && match) state_next = RECEIVE;
            RECEIVE: begin
                if (rx_valid && last_byte)       state_next = CHECK;
                else if (!rx_valid && idle_done) state_next = HUNT;
            end
            CHECK:   state_next = (rx_valid && match) ? RECEIVE : HUNT;
            default: state_next = HUNT;
        endcase
    end

    always_comb begin
        hunt_shift  = rx_valid && (state_reg != RECEIVE);
        sync        = hunt_shift && match;
        accept      = rx_valid && (state_reg == RECEIVE);
        crc_update  = accept && (count_reg < len_cur - 8'd2);
        crc_capture = accept && (count_reg >= len_cur - 8'd2);
        timeout_hit = (state_reg == RECEIVE) && !rx_valid && idle_done;
        good_frame  = (state_reg == CHECK) && crc_ok;
        bad_frame   = (state_reg == CHECK) && !crc_ok;
        busy        = (state_reg == RECEIVE) || (state_reg == CHECK);
    end

    always_ff @(posedge clock48MHz) begin
        if (accept) buffer_reg[count_reg[IW-1:0]] <= rx_byte;
    end

    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_payload
        localparam logic [7:0] IDX = 8'(gi);
        assign payload_next[8*gi +: 8] = (IDX < len_cur) ? buffer_reg[gi] : 8'h00;
    end

    always_ff @(posedge clock48MHz or posedge reset) begin
        if (reset) begin
            window_reg    <= 32'h0;
            crc_reg       <= 16'hFFFF;
            rx_crc_reg    <= 16'h0;
            count_reg     <= 8'h0;
            idle_reg      <= '0;
            type_reg      <= '0;
            frame_valid   <= 1'b0;
            crc_error     <= 1'b0;
            timeout_error <= 1'b0;
            frame_type    <= '0;
            payload_len   <= 8'h0;
            payload       <= '0;
            frames_ok     <= 16'h0;
            crc_err_count <= 16'h0;
        end else begin
            if (hunt_shift)                                window_reg <= window_shift;
            else if (timeout_hit || state_reg == CHECK)    window_reg <= 32'h0;

            if (sync) begin
                type_reg  <= match_type;
                count_reg <= 8'h0;
                crc_reg   <= 16'hFFFF;
            end else if (accept) begin
                count_reg <= count_reg + 8'd1;
            end
            if (crc_update)  crc_reg    <= nextCRC16_D8(rx_byte, crc_reg);
            if (crc_capture) rx_crc_reg <= {rx_crc_reg[7:0], rx_byte};

            if (sync || accept || timeout_hit)    idle_reg <= '0;
            else if (state_reg == RECEIVE)        idle_reg <= idle_reg + 1'b1;

            frame_valid   <= good_frame;
            crc_error     <= bad_frame;
            timeout_error <= timeout_hit;

            if (good_frame) begin
                payload     <= payload_next;
                frame_type  <= type_reg;
                payload_len <= len_cur;
                if (frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
            end
            if (bad_frame && crc_err_count != 16'hFFFF)
                crc_err_count <= crc_err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_coms_frame_rx.sv
// Directed bench for coms_frame_rx: good/bad CRC, type selection, timeout,
// reset mid-frame and back-to-back frames with embedded magics.
module tb_coms_frame_rx;

    localparam int TMO = 100;

    logic         clock48MHz = 1'b0;
    logic         reset      = 1'b1;
    logic         rx_valid   = 1'b0;
    logic [7:0]   rx_byte    = 8'h00;
    logic         frame_valid, crc_error, timeout_error, busy;
    logic [0:0]   frame_type;
    logic [255:0] payload;
    logic [7:0]   payload_len;
    logic [15:0]  frames_ok, crc_err_count;

    coms_frame_rx #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock48MHz    (clock48MHz),
        .reset         (reset),
        .rx_valid      (rx_valid),
        .rx_byte       (rx_byte),
        .frame_valid   (frame_valid),
        .frame_type    (frame_type),
        .payload       (payload),
        .payload_len   (payload_len),
        .crc_error     (crc_error),
        .timeout_error (timeout_error),
        .frames_ok     (frames_ok),
        .crc_err_count (crc_err_count),
        .busy          (busy)
    );

    always #10 clock48MHz = ~clock48MHz;

    int checks = 0, errors = 0;
    int cyc = 0, last_cyc = 0;
    int fv_count = 0, ce_count = 0, to_count = 0;
    int fv_cyc = -1, ce_cyc = -1, to_cyc = -1;
    logic [7:0]   frm[$];
    logic [7:0]   magic_s[$];
    logic [7:0]   magic_c[$];
    logic [255:0] frm_payload, exp_payload;

    always @(posedge clock48MHz) cyc <= cyc + 1;

    always @(negedge clock48MHz) begin
        if (frame_valid)   begin fv_count++; fv_cyc = cyc; end
        if (crc_error)     begin ce_count++; ce_cyc = cyc; end
        if (timeout_error) begin to_count++; to_cyc = cyc; end
    end

    // Byte-wise formulation of CRC-16 poly 0x8005, init FFFF
    function automatic logic [15:0] model_crc(input logic [7:0] b[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < b.size(); i++) begin
            c = c ^ {b[i], 8'h00};
            for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
        end
        return c;
    endfunction

    task automatic make_frame(input logic [7:0] body[$], input logic [7:0] flip);
        logic [15:0] c;
        c = model_crc(body);
        frm = body;
        frm.push_back(c[15:8]);
        frm.push_back(c[7:0] ^ flip);
        frm_payload = '0;
        for (int i = 0; i < frm.size(); i++) frm_payload[8*i +: 8] = frm[i];
    endtask

    task automatic make_body(input logic [7:0] id, input int n, input logic [7:0] base,
                             output logic [7:0] body[$]);
        body.delete();
        body.push_back(id);
        for (int i = 1; i < n; i++) body.push_back(base + 8'(i));
    endtask

    task automatic send_bytes(input logic [7:0] bs[$]);
        for (int i = 0; i < bs.size(); i++) begin
            @(negedge clock48MHz);
            rx_valid = 1'b1;
            rx_byte  = bs[i];
        end
        @(negedge clock48MHz);
        rx_valid = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic settle();
        repeat (4) @(negedge clock48MHz);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock48MHz);
        #1;
        checks++;
        if ({frame_valid, crc_error, timeout_error, busy, frame_type, payload_len,
             frames_ok, crc_err_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got fv=%b ce=%b to=%b busy=%b type=%0d len=%0d ok=%0d cerr=%0d required all 0",
                     frame_valid, crc_error, timeout_error, busy, frame_type, payload_len,
                     frames_ok, crc_err_count);
        end
        checks++;
        if (payload !== '0) begin
            errors++;
            $display("FAIL reset_payload: got %h required 0", payload);
        end
        @(negedge clock48MHz);
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_good_frame();
        logic [7:0] body[$];
        logic [7:0] s[$];
        int fv0;
        fv0 = fv_count;
        make_body(8'h03, 24, 8'h00, body);
        make_frame(body, 8'h00);
        s = {magic_s, frm};
        send_bytes(s);
        settle();
        exp_payload = frm_payload;
        checks++;
        if (fv_count !== fv0 + 1) begin errors++; $display("FAIL good_pulses: got %0d required %0d", fv_count - fv0, 1); end
        checks++;
        if (fv_cyc !== last_cyc + 1) begin errors++; $display("FAIL good_latency: got cycle %0d required %0d", fv_cyc, last_cyc + 1); end
        checks++;
        if (frame_type !== 1'b0 || payload_len !== 8'd26) begin
            errors++; $display("FAIL good_type_len: got type=%0d len=%0d required type=0 len=26", frame_type, payload_len);
        end
        checks++;
        if (payload !== exp_payload || payload[7:0] !== 8'h03) begin
            errors++; $display("FAIL good_payload: got %h required %h", payload, exp_payload);
        end
        checks++;
        if (frames_ok !== 16'd1 || crc_err_count !== 16'd0) begin
            errors++; $display("FAIL good_counters: got ok=%0d cerr=%0d required ok=1 cerr=0", frames_ok, crc_err_count);
        end
        $display("test_good_frame done");
    endtask

    task automatic test_crc_error();
        logic [7:0] body[$];
        logic [7:0] s[$];
        int fv0, ce0;
        fv0 = fv_count; ce0 = ce_count;
        make_body(8'h03, 24, 8'h20, body);
        make_frame(body, 8'h01);
        s = {magic_s, frm};
        send_bytes(s);
        settle();
        checks++;
        if (ce_count !== ce0 + 1 || ce_cyc !== last_cyc + 1) begin
            errors++; $display("FAIL crc_pulse: got count=%0d cycle=%0d required count=1 cycle=%0d", ce_count - ce0, ce_cyc, last_cyc + 1);
        end
        checks++;
        if (fv_count !== fv0) begin errors++; $display("FAIL crc_no_valid: got %0d frame_valid pulses required 0", fv_count - fv0); end
        checks++;
        if (crc_err_count !== 16'd1 || frames_ok !== 16'd1) begin
            errors++; $display("FAIL crc_counters: got cerr=%0d ok=%0d required cerr=1 ok=1", crc_err_count, frames_ok);
        end
        checks++;
        if (payload !== exp_payload) begin errors++; $display("FAIL crc_payload_held: got %h required %h", payload, exp_payload); end
        $display("test_crc_error done");
    endtask

    task automatic test_type1();
        logic [7:0] body[$];
        logic [7:0] s[$];
        int fv0;
        fv0 = fv_count;
        make_body(8'h07, 28, 8'h40, body);
        make_frame(body, 8'h00);
        s = {8'hAA, 8'h1C, 8'hEB, magic_c, frm};
        send_bytes(s);
        settle();
        exp_payload = frm_payload;
        checks++;
        if (fv_count !== fv0 + 1) begin errors++; $display("FAIL type1_pulses: got %0d required 1", fv_count - fv0); end
        checks++;
        if (frame_type !== 1'b1 || payload_len !== 8'd30) begin
            errors++; $display("FAIL type1_type_len: got type=%0d len=%0d required type=1 len=30", frame_type, payload_len);
        end
        checks++;
        if (payload !== exp_payload) begin errors++; $display("FAIL type1_payload: got %h required %h", payload, exp_payload); end
        $display("test_type1 done");
    endtask

    task automatic test_timeout();
        logic [7:0] body[$];
        logic [7:0] s[$];
        int to0, fv0;
        to0 = to_count;
        s = {magic_s, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04};
        send_bytes(s);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_before: got %b required 1", busy); end
        for (int i = 0; i < TMO + 20 && to_count == to0; i++) @(posedge clock48MHz);
        checks++;
        if (to_count !== to0 + 1 || to_cyc !== last_cyc + TMO) begin
            errors++; $display("FAIL timeout_pulse: got count=%0d cycle=%0d required count=1 cycle=%0d", to_count - to0, to_cyc, last_cyc + TMO);
        end
        @(negedge clock48MHz);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_after: got %b required 0", busy); end
        fv0 = fv_count;
        make_body(8'h05, 24, 8'h60, body);
        make_frame(body, 8'h00);
        s = {magic_s, frm};
        send_bytes(s);
        settle();
        exp_payload = frm_payload;
        checks++;
        if (fv_count !== fv0 + 1 || frames_ok !== 16'd3 || payload !== exp_payload) begin
            errors++; $display("FAIL timeout_recover: got pulses=%0d ok=%0d required pulses=1 ok=3", fv_count - fv0, frames_ok);
        end
        $display("test_timeout done");
    endtask

    task automatic test_terminal_byte();
        logic [7:0] body[$];
        logic [7:0] s1[$];
        logic [7:0] s2[$];
        int to0, fv0;
        to0 = to_count; fv0 = fv_count;
        make_body(8'h09, 24, 8'h80, body);
        make_frame(body, 8'h00);
        s1 = magic_s;
        for (int i = 0; i < 2; i++) s1.push_back(frm[i]);
        for (int i = 2; i < frm.size(); i++) s2.push_back(frm[i]);
        send_bytes(s1);
        repeat (TMO - 2) @(negedge clock48MHz);
        send_bytes(s2);
        settle();
        checks++;
        if (to_count !== to0 || fv_count !== fv0 + 1) begin
            errors++; $display("FAIL terminal_byte_wins: got timeouts=%0d frames=%0d required timeouts=0 frames=1", to_count - to0, fv_count - fv0);
        end
        $display("test_terminal_byte done");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] body[$];
        logic [7:0] s[$];
        int fv0, ce0, to0;
        s = {magic_s, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_bytes(s);
        fv0 = fv_count; ce0 = ce_count; to0 = to_count;
        reset = 1'b1;
        repeat (3) @(negedge clock48MHz);
        #1;
        checks++;
        if (busy !== 1'b0 || frames_ok !== 16'd0 || crc_err_count !== 16'd0 || payload !== '0) begin
            errors++; $display("FAIL midreset_state: got busy=%b ok=%0d cerr=%0d required busy=0 ok=0 cerr=0", busy, frames_ok, crc_err_count);
        end
        checks++;
        if (fv_count !== fv0 || ce_count !== ce0 || to_count !== to0) begin
            errors++; $display("FAIL midreset_pulses: got fv=%0d ce=%0d to=%0d required 0 0 0", fv_count - fv0, ce_count - ce0, to_count - to0);
        end
        reset = 1'b0;
        make_body(8'h02, 24, 8'hA0, body);
        make_frame(body, 8'h00);
        s = {magic_s, frm};
        send_bytes(s);
        settle();
        exp_payload = frm_payload;
        checks++;
        if (fv_count !== fv0 + 1 || frames_ok !== 16'd1 || payload !== exp_payload) begin
            errors++; $display("FAIL midreset_recover: got pulses=%0d ok=%0d required pulses=1 ok=1", fv_count - fv0, frames_ok);
        end
        $display("test_reset_mid_frame done");
    endtask

    task automatic test_back_to_back();
        logic [7:0] body[$];
        logic [7:0] fa[$];
        logic [7:0] s[$];
        int fv0, ce0;
        fv0 = fv_count; ce0 = ce_count;
        make_body(8'h04, 24, 8'h10, body);
        body[1] = 8'h1C; body[2] = 8'hEB; body[3] = 8'h00; body[4] = 8'hDA;
        body[8] = 8'hBA; body[9] = 8'hAD; body[10] = 8'hA5; body[11] = 8'h55;
        make_frame(body, 8'h00);
        fa = frm;
        make_body(8'h06, 24, 8'hC0, body);
        make_frame(body, 8'h00);
        s = {magic_s, fa, magic_s, frm};
        send_bytes(s);
        settle();
        exp_payload = frm_payload;
        checks++;
        if (fv_count !== fv0 + 2 || ce_count !== ce0) begin
            errors++; $display("FAIL b2b_pulses: got valid=%0d crcerr=%0d required valid=2 crcerr=0", fv_count - fv0, ce_count - ce0);
        end
        checks++;
        if (frames_ok !== 16'd3) begin errors++; $display("FAIL b2b_frames_ok: got %0d required 3", frames_ok); end
        checks++;
        if (payload !== exp_payload || frame_type !== 1'b0) begin
            errors++; $display("FAIL b2b_payload: got %h required %h", payload, exp_payload);
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        magic_s = {8'h1C, 8'hEB, 8'h00, 8'hDA};
        magic_c = {8'hBA, 8'hAD, 8'hA5, 8'h55};
        test_reset();
        test_good_frame();
        test_crc_error();
        test_type1();
        test_timeout();
        test_terminal_byte();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
